buzzer_scheduler: RTL and testbench



---
 rtl/buzzer_pkg.sv | 54 +++++
 rtl/buzzer_tone_gen.sv | 35 +++
 rtl/buzzer_scheduler.sv | 173 +++++++++++++++++
 tb/tb_buzzer_scheduler.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/buzzer_pkg.sv
// Shared types and helpers for the buzzer scheduler: source ids, FSM states,
// fixed-priority encoding (ALARM > FAIL > OK > KEY) and per-source bit masks.
package buzzer_pkg;

  typedef enum logic [2:0] {
    SRC_NONE  = 3'd0,
    SRC_KEY   = 3'd1,
    SRC_OK    = 3'd2,
    SRC_FAIL  = 3'd3,
    SRC_ALARM = 3'd4
  } src_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TONE = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  localparam int NUM_SRC = 4;

  // Request vector bit order: [3]=ALARM [2]=FAIL [1]=OK [0]=KEY
  function automatic src_t prio_encode(input logic [NUM_SRC-1:0] req);
    if (req[3])      return SRC_ALARM;
    else if (req[2]) return SRC_FAIL;
    else if (req[1]) return SRC_OK;
    else if (req[0]) return SRC_KEY;
    else             return SRC_NONE;
  endfunction

  function automatic logic [NUM_SRC-1:0] src_bit(input src_t s);
    case (s)
      SRC_KEY:   return 4'b0001;
      SRC_OK:    return 4'b0010;
      SRC_FAIL:  return 4'b0100;
      SRC_ALARM: return 4'b1000;
      default:   return 4'b0000;
    endcase
  endfunction

  // Bits of every source strictly below s in priority.
  function automatic logic [NUM_SRC-1:0] lower_mask(input src_t s);
    case (s)
      SRC_OK:    return 4'b0001;
      SRC_FAIL:  return 4'b0011;
      SRC_ALARM: return 4'b0111;
      default:   return 4'b0000;
    endcase
  endfunction

  function automatic int unsigned umax(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/buzzer_tone_gen.sv
// Half-period divider: phase toggles every `half` enabled cycles; restart
// forces phase high and reloads the count so every burst starts on a high level.
module buzzer_tone_gen #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          restart,
  input  logic          en,
  input  logic [CW-1:0] half,
  output logic          phase
);

  localparam logic [CW-1:0] ONE = CW'(1);

  logic [CW-1:0] hcnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      phase <= 1'b0;
      hcnt  <= '0;
    end else if (restart) begin
      phase <= 1'b1;
      hcnt  <= ONE;
    end else if (en) begin
      if (hcnt >= half) begin
        phase <= ~phase;
        hcnt  <= ONE;
      end else begin
        hcnt  <= hcnt + ONE;
      end
    end
  end

endmodule

// File: rtl/buzzer_scheduler.sv
// Shares one piezo buzzer among key/ok/fail/alarm sources with fixed-priority
// preemption. Define BUZZER_QUEUE_EN to queue lower-priority requests (one pending bit per source).
module buzzer_scheduler
  import buzzer_pkg::*;
#(
  parameter int unsigned KEY_HALF   = 50000,
  parameter int unsigned KEY_ON     = 10000000,
  parameter int unsigned OK_HALF    = 25000,
  parameter int unsigned OK_ON      = 30000000,
  parameter int unsigned FAIL_HALF  = 100000,
  parameter int unsigned FAIL_ON    = 5000000,
  parameter int unsigned FAIL_OFF   = 5000000,
  parameter int unsigned FAIL_REPS  = 2,
  parameter int unsigned ALARM_HALF = 12500,
  parameter int unsigned ALARM_ON   = 25000000,
  parameter int unsigned ALARM_OFF  = 25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_key,
  input  logic       req_ok,
  input  logic       req_fail,
  input  logic       req_alarm,
  input  logic       alarm_clr,
  output logic       buzzer,
  output logic       busy,
  output logic [2:0] active_src,
  output logic       done
);

  localparam int unsigned MAX_P =
    umax(umax(umax(KEY_HALF, KEY_ON), umax(OK_HALF, OK_ON)),
         umax(umax(umax(FAIL_HALF, FAIL_ON), umax(FAIL_OFF, FAIL_REPS)),
              umax(ALARM_HALF, umax(ALARM_ON, ALARM_OFF))));
  localparam int CW = $clog2(MAX_P) + 1;

  localparam logic [CW-1:0] ONE     = CW'(1);
  localparam logic [CW-1:0] K_HALF  = CW'(KEY_HALF);
  localparam logic [CW-1:0] K_ON    = CW'(KEY_ON);
  localparam logic [CW-1:0] O_HALF  = CW'(OK_HALF);
  localparam logic [CW-1:0] O_ON    = CW'(OK_ON);
  localparam logic [CW-1:0] F_HALF  = CW'(FAIL_HALF);
  localparam logic [CW-1:0] F_ON    = CW'(FAIL_ON);
  localparam logic [CW-1:0] F_OFF   = CW'(FAIL_OFF);
  localparam logic [CW-1:0] F_REPS  = CW'(FAIL_REPS);
  localparam logic [CW-1:0] A_HALF  = CW'(ALARM_HALF);
  localparam logic [CW-1:0] A_ON    = CW'(ALARM_ON);
  localparam logic [CW-1:0] A_OFF   = CW'(ALARM_OFF);

  state_t        state, state_n;
  src_t          src, src_n, win;
  logic [CW-1:0] cnt, cnt_n, burst, burst_n;
  logic [CW-1:0] half_c, on_c, off_c;
  logic [3:0]    req_v, cand;
  logic          done_n, restart, more, tone_en, phase;

  // A simultaneous clear suppresses the alarm request.
  assign req_v = {req_alarm & ~alarm_clr, req_fail, req_ok, req_key};

`ifdef BUZZER_QUEUE_EN
  logic [3:0] pend, pend_n;

  assign cand   = (state == ST_IDLE) ? (req_v | pend) : req_v;
  assign pend_n = (pend | (req_v & lower_mask(src_n))) & ~src_bit(src_n);

  always_ff @(posedge clk) begin
    if (rst) pend <= '0;
    else     pend <= pend_n;
  end
`else
  assign cand = req_v;
`endif

  always_comb begin
    half_c = K_HALF;
    on_c   = K_ON;
    off_c  = ONE;
    case (src)
      SRC_OK:    begin half_c = O_HALF; on_c = O_ON; end
      SRC_FAIL:  begin half_c = F_HALF; on_c = F_ON; off_c = F_OFF; end
      SRC_ALARM: begin half_c = A_HALF; on_c = A_ON; off_c = A_OFF; end
      default:   ;
    endcase
  end

  assign more = (src == SRC_ALARM) || ((src == SRC_FAIL) && (burst < F_REPS));
  assign win  = prio_encode(cand);

  always_comb begin
    state_n = state;
    src_n   = src;
    cnt_n   = cnt;
    burst_n = burst;
    done_n  = 1'b0;
    restart = 1'b0;
    if ((state != ST_IDLE) && (src == SRC_ALARM) && alarm_clr) begin
      state_n = ST_IDLE;
      src_n   = SRC_NONE;
      cnt_n   = '0;
      burst_n = '0;
      done_n  = 1'b1;
    end else if ((win != SRC_NONE) && ((state == ST_IDLE) || (win >= src))) begin
      // New, preempting or same-source request: start from the first burst.
      state_n = ST_TONE;
      src_n   = win;
      cnt_n   = ONE;
      burst_n = ONE;
      restart = 1'b1;
    end else begin
      case (state)
        ST_TONE: begin
          if (cnt >= on_c) begin
            cnt_n = ONE;
            if (more) begin
              state_n = ST_GAP;
            end else begin
              state_n = ST_IDLE;
              src_n   = SRC_NONE;
              cnt_n   = '0;
              burst_n = '0;
              done_n  = 1'b1;
            end
          end else begin
            cnt_n = cnt + ONE;
          end
        end
        ST_GAP: begin
          if (cnt >= off_c) begin
            state_n = ST_TONE;
            cnt_n   = ONE;
            restart = 1'b1;
            if (burst < F_REPS) burst_n = burst + ONE;
          end else begin
            cnt_n = cnt + ONE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      src   <= SRC_NONE;
      cnt   <= '0;
      burst <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      src   <= src_n;
      cnt   <= cnt_n;
      burst <= burst_n;
      done  <= done_n;
    end
  end

  assign tone_en = (state == ST_TONE);

  buzzer_tone_gen #(.CW(CW)) u_tone (
    .clk     (clk),
    .rst     (rst),
    .restart (restart),
    .en      (tone_en),
    .half    (half_c),
    .phase   (phase)
  );

  assign buzzer     = tone_en & phase;
  assign busy       = (state != ST_IDLE);
  assign active_src = src;

endmodule

// File: tb/tb_buzzer_scheduler.sv
// Scoreboard bench for buzzer_scheduler: stimulus queues per-cycle expected
// {buzzer,busy,active_src,done}; a negedge monitor compares entries due that cycle.
module tb_buzzer_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_key = 1'b0, req_ok = 1'b0, req_fail = 1'b0, req_alarm = 1'b0;
  logic       alarm_clr = 1'b0;
  logic       buzzer, busy, done;
  logic [2:0] active_src;

  int cyc    = 0;
  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    int          cyc;
    string       name;
    logic [5:0]  exp;
  } exp_t;

  exp_t sbq[$];

  buzzer_scheduler #(
    .KEY_HALF(2), .KEY_ON(8), .OK_HALF(1), .OK_ON(6),
    .FAIL_HALF(3), .FAIL_ON(6), .FAIL_OFF(4), .FAIL_REPS(2),
    .ALARM_HALF(1), .ALARM_ON(4), .ALARM_OFF(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_key    (req_key),
    .req_ok     (req_ok),
    .req_fail   (req_fail),
    .req_alarm  (req_alarm),
    .alarm_clr  (alarm_clr),
    .buzzer     (buzzer),
    .busy       (busy),
    .active_src (active_src),
    .done       (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [5:0] pk(input bit bz, input bit by, input int s, input bit d);
    return {bz, by, 3'(s), d};
  endfunction

  task automatic push(input int c, input string nm, input logic [5:0] e);
    exp_t x;
    x.cyc = c; x.name = nm; x.exp = e;
    sbq.push_back(x);
  endtask

  // Tone cycles, pattern given MSB-first.
  task automatic push_bits(input int c, input string nm, input int n, input logic [31:0] bits, input int s);
    for (int i = 0; i < n; i++) push(c + i, nm, pk(bits[n-1-i], 1'b1, s, 1'b0));
  endtask

  task automatic push_gap(input int c, input string nm, input int n, input int s);
    for (int i = 0; i < n; i++) push(c + i, nm, pk(1'b0, 1'b1, s, 1'b0));
  endtask

  task automatic push_idle(input int c, input string nm, input int n);
    for (int i = 0; i < n; i++) push(c + i, nm, pk(1'b0, 1'b0, 0, 1'b0));
  endtask

  task automatic push_done(input int c, input string nm);
    push(c, nm, pk(1'b0, 1'b0, 0, 1'b1));
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic do_reset();
    int c;
    step(); c = cyc; rst = 1'b1;
    push(c + 1, "reset", pk(1'b0, 1'b0, 0, 1'b0));
    step(); rst = 1'b0;
    push(c + 2, "reset_release", pk(1'b0, 1'b0, 0, 1'b0));
    step();
  endtask

  // Monitor
  always @(negedge clk) begin
    logic [5:0] act;
    act = {buzzer, busy, active_src, done};
    for (int i = sbq.size() - 1; i >= 0; i--) begin
      if (sbq[i].cyc == cyc) begin
        n_chk++;
        if (act !== sbq[i].exp) begin
          n_fail++;
          $display("FAIL %s cyc=%0d actual{bz,busy,src,done}=%b required=%b",
                   sbq[i].name, cyc, act, sbq[i].exp);
        end
        sbq.delete(i);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish, %0d/%0d checks passed", n_chk - n_fail, n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    do_reset();

    n_chk++;
    if ({buzzer, busy, active_src, done} !== 6'b000000) begin
      n_fail++;
      $display("FAIL post_reset_direct cyc=%0d actual=%b", cyc, {buzzer, busy, active_src, done});
    end

    // Key click; alarm_clr while KEY plays is ignored
    step(); c = cyc; req_key = 1'b1;
    push_bits(c + 1, "key_tone", 8, 32'b11001100, 1);
    push_done(c + 9, "key_done");
    push_idle(c + 10, "key_idle", 1);
    step(); req_key = 1'b0;
    wait_cyc(c + 2); alarm_clr = 1'b1;
    step(); alarm_clr = 1'b0;
    wait_cyc(c + 11);

    n_chk++;
    if ({buzzer, busy, active_src, done} !== 6'b000000) begin
      n_fail++;
      $display("FAIL key_after_direct cyc=%0d actual=%b", cyc, {buzzer, busy, active_src, done});
    end

    // Reject: two bursts with a gap
    c = cyc; req_fail = 1'b1;
    push_bits(c + 1, "fail_b1", 6, 32'b111000, 3);
    push_gap(c + 7, "fail_gap", 4, 3);
    push_bits(c + 11, "fail_b2", 6, 32'b111000, 3);
    push_done(c + 17, "fail_done");
    push_idle(c + 18, "fail_idle", 1);
    step(); req_fail = 1'b0;
    wait_cyc(c + 19);

    // Preemption: FAIL 3 cycles into KEY, no KEY done
    c = cyc; req_key = 1'b1;
    push_bits(c + 1, "pre_key", 3, 32'b110, 1);
    push_bits(c + 4, "pre_fail_b1", 6, 32'b111000, 3);
    push_gap(c + 10, "pre_fail_gap", 4, 3);
    push_bits(c + 14, "pre_fail_b2", 6, 32'b111000, 3);
    push_done(c + 20, "pre_done");
    push_idle(c + 21, "pre_idle", 1);
    step(); req_key = 1'b0;
    wait_cyc(c + 3); req_fail = 1'b1;
    step(); req_fail = 1'b0;
    wait_cyc(c + 22);

    // Lower-priority OK during FAIL
    c = cyc; req_fail = 1'b1;
    push_bits(c + 1, "q_fail_b1", 6, 32'b111000, 3);
    push_gap(c + 7, "q_fail_gap", 4, 3);
    push_bits(c + 11, "q_fail_b2", 6, 32'b111000, 3);
    push_done(c + 17, "q_fail_done");
`ifdef BUZZER_QUEUE_EN
    push_bits(c + 18, "q_ok_tone", 6, 32'b101010, 2);
    push_done(c + 24, "q_ok_done");
    push_idle(c + 25, "q_idle", 1);
`else
    push_idle(c + 18, "q_ok_dropped", 8);
`endif
    step(); req_fail = 1'b0;
    wait_cyc(c + 2); req_ok = 1'b1;
    step(); req_ok = 1'b0;
    wait_cyc(c + 26);

    // Same-source restart from the gap
    c = cyc; req_fail = 1'b1;
    push_bits(c + 1, "rs_b1", 6, 32'b111000, 3);
    push_gap(c + 7, "rs_gap_cut", 2, 3);
    push_bits(c + 9, "rs_new_b1", 6, 32'b111000, 3);
    push_gap(c + 15, "rs_new_gap", 4, 3);
    push_bits(c + 19, "rs_new_b2", 6, 32'b111000, 3);
    push_done(c + 25, "rs_done");
    push_idle(c + 26, "rs_idle", 1);
    step(); req_fail = 1'b0;
    wait_cyc(c + 8); req_fail = 1'b1;
    step(); req_fail = 1'b0;
    wait_cyc(c + 27);

    // Alarm: three on/off cycles, then clear
    c = cyc; req_alarm = 1'b1;
    for (int k = 0; k < 3; k++) begin
      push_bits(c + 1 + 8*k, "alarm_on", 4, 32'b1010, 4);
      push_gap(c + 5 + 8*k, "alarm_off", 4, 4);
    end
    push_bits(c + 25, "alarm_last", 1, 32'b1, 4);
    push_done(c + 26, "alarm_clr_done");
    push_idle(c + 27, "alarm_clr_idle", 1);
    step(); req_alarm = 1'b0;
    wait_cyc(c + 25); alarm_clr = 1'b1;
    step(); alarm_clr = 1'b0;
    wait_cyc(c + 28);

    // req_alarm with alarm_clr in the same cycle: not started
    c = cyc; req_alarm = 1'b1; alarm_clr = 1'b1;
    push_idle(c + 1, "alarm_clr_wins", 2);
    step(); req_alarm = 1'b0; alarm_clr = 1'b0;
    wait_cyc(c + 3);

    // Simultaneous KEY+OK: OK wins
    c = cyc; req_key = 1'b1; req_ok = 1'b1;
    push_bits(c + 1, "prio_ok", 6, 32'b101010, 2);
    push_done(c + 7, "prio_ok_done");
    step(); req_key = 1'b0; req_ok = 1'b0;
    wait_cyc(c + 8);
    do_reset();

    // Reset mid-alarm
    step(); c = cyc; req_alarm = 1'b1;
    push_bits(c + 1, "rst_alarm", 3, 32'b101, 4);
    push(c + 4, "rst_mid_alarm", pk(1'b0, 1'b0, 0, 1'b0));
    push_idle(c + 5, "rst_after", 2);
    step(); req_alarm = 1'b0;
    wait_cyc(c + 3); rst = 1'b1;
    step(); rst = 1'b0;
    wait_cyc(c + 8);

    n_chk++;
    if ({buzzer, busy, active_src, done} !== 6'b000000) begin
      n_fail++;
      $display("FAIL rst_alarm_final_direct cyc=%0d actual=%b", cyc, {buzzer, busy, active_src, done});
    end

    foreach (sbq[i]) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s never checked (due cyc=%0d)", sbq[i].name, sbq[i].cyc);
    end
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
